// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage pending-write scoreboard and the
// latency classes the datapath controller attaches to each instruction.
package id_hazard_scoreboard_pkg;

    localparam int NUM_REGS_DEFAULT = 32;
    localparam int MAX_LAT_DEFAULT  = 8;
    localparam int FWD_LAT_DEFAULT  = 1;
    localparam int REG_ADDR_W       = 5;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 4;
    localparam int LAT_DIV  = MAX_LAT_DEFAULT;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage request bundle and the pipeline-control responses of the scoreboard.
interface id_hazard_scoreboard_if
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = $clog2(MAX_LAT_DEFAULT + 2)
) ();

    logic                  ID_Valid;
    logic [REG_ADDR_W-1:0] ID_Rs;
    logic [REG_ADDR_W-1:0] ID_Rt;
    logic                  ID_UsesRs;
    logic                  ID_UsesRt;
    logic [REG_ADDR_W-1:0] ID_Rd;
    logic                  ID_RegWrite;
    logic [CNT_W-1:0]      ID_Latency;
    logic                  Flush;

    logic                  Stall;
    logic                  Issue;
    logic                  PC_WriteEnable;
    logic                  IFIDWriteEnable;
    logic                  IDEXFlush;
    logic                  Busy;
    logic [31:0]           StallCount;

    modport master (
        output ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Rd,
               ID_RegWrite, ID_Latency, Flush,
        input  Stall, Issue, PC_WriteEnable, IFIDWriteEnable, IDEXFlush,
               Busy, StallCount
    );

    modport slave (
        input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Rd,
               ID_RegWrite, ID_Latency, Flush,
        output Stall, Issue, PC_WriteEnable, IFIDWriteEnable, IDEXFlush,
               Busy, StallCount
    );

endinterface

// File: rtl/id_hazard_scoreboard_entry.sv
// One architectural register's pending-write down-counter together with the
// RAW, WAW and writeback-port compares against the instruction in ID.
module scoreboard_entry
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int IDX     = 1,
    parameter int CNT_W   = 4,
    parameter int FWD_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  uses_rs_i,
    input  logic                  uses_rt_i,
    input  logic                  track_i,
    input  logic                  issue_i,
    input  logic [CNT_W-1:0]      lat_i,
    input  logic [CNT_W-1:0]      lat_p1_i,
    output logic                  raw_o,
    output logic                  waw_o,
    output logic                  port_o,
    output logic                  nz_d_o
);

    localparam logic [REG_ADDR_W-1:0] ADDR = REG_ADDR_W'(IDX);
    localparam logic [CNT_W-1:0]      FWD  = CNT_W'(FWD_LAT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sel_rd;

    assign sel_rd = track_i && (rd_i == ADDR);
    assign raw_o  = ((uses_rs_i && (rs_i == ADDR)) || (uses_rt_i && (rt_i == ADDR)))
                    && (cnt_q > FWD);
    assign waw_o  = sel_rd && (cnt_q > lat_i);
    assign port_o = (cnt_q == lat_p1_i);

    // NOTE: a new issue to this register overrides the decrement of the old write.
    always_comb begin
        cnt_d = cnt_q;
        if (issue_i && sel_rd) begin
            cnt_d = lat_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign nz_d_o = |cnt_d;

    // NOTE: sequential state uses non-blocking assignments so all entries update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard unit: per-register pending-write counters decide stall and
// issue, drive PC/IF-ID enables and the ID/EX flush, and count stalled cycles.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int MAX_LAT  = MAX_LAT_DEFAULT,
    parameter int FWD_LAT  = FWD_LAT_DEFAULT,
    parameter int CNT_W    = $clog2(MAX_LAT + 2)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    id_hazard_scoreboard_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LAT);

    logic [CNT_W-1:0]    lat_eff;
    logic [CNT_W-1:0]    lat_p1;
    logic                track;
    logic                stall;
    logic                issue;
    logic [NUM_REGS-1:1] raw_v;
    logic [NUM_REGS-1:1] waw_v;
    logic [NUM_REGS-1:1] port_v;
    logic [NUM_REGS-1:1] nz_d_v;
    logic                busy_q;
    logic [31:0]         stall_cnt_q;

    always_comb begin
        lat_eff = bus.ID_Latency;
        if (bus.ID_Latency == '0) begin
            lat_eff = CNT_W'(1);
        end else if (bus.ID_Latency > MAX_L) begin
            lat_eff = MAX_L;
        end
    end

    assign lat_p1 = lat_eff + CNT_W'(1);
    assign track  = bus.ID_RegWrite && (bus.ID_Rd != '0);

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        scoreboard_entry #(
            .IDX     (r),
            .CNT_W   (CNT_W),
            .FWD_LAT (FWD_LAT)
        ) u_entry (
            .clk_i     (Clock),
            .rst_i     (Reset),
            .rs_i      (bus.ID_Rs),
            .rt_i      (bus.ID_Rt),
            .rd_i      (bus.ID_Rd),
            .uses_rs_i (bus.ID_UsesRs),
            .uses_rt_i (bus.ID_UsesRt),
            .track_i   (track),
            .issue_i   (issue),
            .lat_i     (lat_eff),
            .lat_p1_i  (lat_p1),
            .raw_o     (raw_v[r]),
            .waw_o     (waw_v[r]),
            .port_o    (port_v[r]),
            .nz_d_o    (nz_d_v[r])
        );
    end

    // Reset forces the pipeline-control outputs to their idle values.
    assign stall = bus.ID_Valid && !Reset
                   && ((|raw_v) || (|waw_v) || (track && (|port_v)));
    assign issue = bus.ID_Valid && !stall && !bus.Flush && !Reset;

    assign bus.Stall           = stall;
    assign bus.Issue           = issue;
    assign bus.PC_WriteEnable  = !stall;
    assign bus.IFIDWriteEnable = !stall;
    assign bus.IDEXFlush       = stall || (bus.Flush && !Reset);
    assign bus.Busy            = busy_q;
    assign bus.StallCount      = stall_cnt_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            busy_q <= |nz_d_v;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule
